// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 request arbiter: requester indices,
// L2-side id width helper and the default-geometry request record.
package l2_arb_pkg;

    // Requester indices: port 0 is the D-cache, port 1 is the I-cache
    localparam logic REQ_D = 1'b0;
    localparam logic REQ_I = 1'b1;

    // Default geometry used by the packaged request record
    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_LINE_WIDTH   = 256;
    localparam int DEF_MSHR_ID_BITS = 4;

    // The L2 side id carries one extra bit naming the requesting cache
    function automatic int l2IdWidth(input int mshrIdBits);
        return mshrIdBits + 1;
    endfunction

    // One request as presented to the L2 controller (default geometry)
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]               addr;
        logic [DEF_LINE_WIDTH-1:0]               data;
        logic                                    rw;
        logic [l2IdWidth(DEF_MSHR_ID_BITS)-1:0]  id;
    } l2Req_t;

endpackage

// File: rtl/l2_req_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. A single pointer bit names the favoured
// port when both request; it moves to the other port after every grant
// that is actually taken (advance_i).
module rr_arbiter2
    import l2_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant the lone requester, or the pointer's favourite when both ask
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o[REQ_D] = 1'b1;
            2'b10:   grant_o[REQ_I] = 1'b1;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // After a taken grant the port that did not win becomes the favourite
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (grant_o != 2'b00)) begin
            ptr_d = grant_o[REQ_D];
        end
    end

    // Pointer register, cleared to favour the D-cache
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/l2_req_arbiter.sv
// Shares one L2 request/response port between the D-cache (port 0) and
// the I-cache (port 1). Requests are arbitrated round-robin into a single
// registered output stage; responses are routed back by the requester bit
// carried in the top of the L2 id. Per-port read counters bound the number
// of outstanding reads and flag responses nobody was waiting for.
module l2_req_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 256,
    parameter int MSHR_ID_BITS = 4,
    parameter int MAX_OUTST    = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [1:0][ADDR_WIDTH-1:0]            l1_addr_i,
    input  logic [1:0][LINE_WIDTH-1:0]            l1_data_i,
    input  logic [1:0]                            l1_rw_i,
    input  logic [1:0]                            l1_valid_i,
    input  logic [1:0][MSHR_ID_BITS-1:0]          l1_id_i,
    output logic [1:0]                            l1_stall_o,
    output logic [1:0][LINE_WIDTH-1:0]            l1_data_o,
    output logic [1:0]                            l1_valid_o,
    output logic [1:0][MSHR_ID_BITS-1:0]          l1_id_o,
    output logic [ADDR_WIDTH-1:0]                 l2_addr_o,
    output logic [LINE_WIDTH-1:0]                 l2_data_o,
    output logic                                  l2_rw_o,
    output logic                                  l2_valid_o,
    output logic [l2IdWidth(MSHR_ID_BITS)-1:0]    l2_id_o,
    input  logic                                  l2_stall_i,
    input  logic [LINE_WIDTH-1:0]                 l2_data_i,
    input  logic                                  l2_valid_i,
    input  logic [l2IdWidth(MSHR_ID_BITS)-1:0]    l2_id_i,
    output logic                                  err_o
);

    localparam int L2_ID_W = l2IdWidth(MSHR_ID_BITS);
    localparam int CNT_W   = $clog2(MAX_OUTST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
        logic                  rw;
        logic [L2_ID_W-1:0]    id;
    } stageReq_t;

    logic [1:0]             eligible;
    logic [1:0]             grant;
    logic                   grantIdx;
    logic                   drain;
    logic                   canLoad;
    logic                   accept;

    logic                   stageValid_q;
    logic                   stageValid_d;
    stageReq_t              stage_q;
    stageReq_t              stage_d;

    logic [1:0][CNT_W-1:0]  cnt_q;
    logic [1:0][CNT_W-1:0]  cnt_d;
    logic [1:0]             readInc;
    logic [1:0]             rspDec;
    logic                   rspPort;
    logic                   rspToEmpty;

    logic                   err_q;
    logic                   err_d;
    logic [1:0]             rspValid_q;
    logic [1:0]             rspValid_d;
    logic [MSHR_ID_BITS-1:0] rspId_q;
    logic [MSHR_ID_BITS-1:0] rspId_d;
    logic [LINE_WIDTH-1:0]  rspData_q;
    logic [LINE_WIDTH-1:0]  rspData_d;

    // A port may compete unless it is a read and its read budget is used up
    always_comb begin
        eligible = 2'b00;
        for (int p = 0; p < 2; p++) begin
            eligible[p] = l1_valid_i[p] & ~(~l1_rw_i[p] & (cnt_q[p] == CNT_MAX));
        end
    end

    rr_arbiter2 u_rrArb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (eligible),
        .advance_i (accept),
        .grant_o   (grant)
    );

    // The stage can take a new request when empty or emptying this cycle
    always_comb begin
        drain    = stageValid_q & ~l2_stall_i;
        canLoad  = ~stageValid_q | drain;
        grantIdx = grant[REQ_I] ? REQ_I : REQ_D;
        accept   = canLoad & (grant != 2'b00);
    end

    // A requester is held off whenever its request is not taken this cycle
    always_comb begin
        l1_stall_o = 2'b00;
        for (int p = 0; p < 2; p++) begin
            l1_stall_o[p] = reset & l1_valid_i[p] & ~(grant[p] & canLoad);
        end
    end

    // Load the winner into the stage, otherwise let a draining stage empty
    always_comb begin
        stageValid_d = stageValid_q;
        stage_d      = stage_q;
        if (accept) begin
            stageValid_d = 1'b1;
            stage_d.addr = l1_addr_i[grantIdx];
            stage_d.data = l1_data_i[grantIdx];
            stage_d.rw   = l1_rw_i[grantIdx];
            stage_d.id   = {grantIdx, l1_id_i[grantIdx]};
        end else if (drain) begin
            stageValid_d = 1'b0;
        end
    end

    // Count reads in on acceptance and out on their response; a response to
    // a port with nothing outstanding is flagged and does not decrement
    always_comb begin
        rspPort    = l2_id_i[MSHR_ID_BITS];
        rspToEmpty = l2_valid_i & (cnt_q[rspPort] == '0);
        readInc    = 2'b00;
        rspDec     = 2'b00;
        cnt_d      = cnt_q;
        for (int p = 0; p < 2; p++) begin
            readInc[p] = accept & grant[p] & ~l1_rw_i[p];
            rspDec[p]  = l2_valid_i & (rspPort == 1'(p)) & (cnt_q[p] != '0);
            cnt_d[p]   = cnt_q[p] + CNT_W'(readInc[p]) - CNT_W'(rspDec[p]);
        end
        err_d = err_q | rspToEmpty;
    end

    // Route each L2 response to the cache named by its top id bit
    always_comb begin
        rspValid_d = 2'b00;
        rspId_d    = rspId_q;
        rspData_d  = rspData_q;
        if (l2_valid_i) begin
            rspValid_d[rspPort] = 1'b1;
            rspId_d             = l2_id_i[MSHR_ID_BITS-1:0];
            rspData_d           = l2_data_i;
        end
    end

    // All architectural state, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stageValid_q <= 1'b0;
            stage_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rspValid_q   <= 2'b00;
            rspId_q      <= '0;
            rspData_q    <= '0;
        end else begin
            stageValid_q <= stageValid_d;
            stage_q      <= stage_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rspValid_q   <= rspValid_d;
            rspId_q      <= rspId_d;
            rspData_q    <= rspData_d;
        end
    end

    assign l2_valid_o   = stageValid_q;
    assign l2_addr_o    = stage_q.addr;
    assign l2_data_o    = stage_q.data;
    assign l2_rw_o      = stage_q.rw;
    assign l2_id_o      = stage_q.id;
    assign l1_valid_o   = rspValid_q;
    assign l1_id_o[0]   = rspId_q;
    assign l1_id_o[1]   = rspId_q;
    assign l1_data_o[0] = rspData_q;
    assign l1_data_o[1] = rspData_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: a table of single-request
// vectors, hand-written multi-cycle sequences and a randomized run, all
// compared against a transaction-level model of the arbiter.
module tb_l2_req_arbiter;

    localparam int ADDR_WIDTH   = 32;
    localparam int LINE_WIDTH   = 256;
    localparam int MSHR_ID_BITS = 4;
    localparam int MAX_OUTST    = 8;

    logic                          clk;
    logic                          reset;
    logic [1:0][ADDR_WIDTH-1:0]    l1_addr_i;
    logic [1:0][LINE_WIDTH-1:0]    l1_data_i;
    logic [1:0]                    l1_rw_i;
    logic [1:0]                    l1_valid_i;
    logic [1:0][MSHR_ID_BITS-1:0]  l1_id_i;
    logic [1:0]                    l1_stall_o;
    logic [1:0][LINE_WIDTH-1:0]    l1_data_o;
    logic [1:0]                    l1_valid_o;
    logic [1:0][MSHR_ID_BITS-1:0]  l1_id_o;
    logic [ADDR_WIDTH-1:0]         l2_addr_o;
    logic [LINE_WIDTH-1:0]         l2_data_o;
    logic                          l2_rw_o;
    logic                          l2_valid_o;
    logic [MSHR_ID_BITS:0]         l2_id_o;
    logic                          l2_stall_i;
    logic [LINE_WIDTH-1:0]         l2_data_i;
    logic                          l2_valid_i;
    logic [MSHR_ID_BITS:0]         l2_id_i;
    logic                          err_o;

    int errors;
    int checks;

    // Transaction-level model state
    bit                    mStageValid;
    logic [ADDR_WIDTH-1:0] mAddr;
    logic [LINE_WIDTH-1:0] mData;
    logic                  mRw;
    logic [MSHR_ID_BITS:0] mId;
    int                    mPrefer;
    int                    mCnt[2];
    bit                    mErr;
    bit                    mRspValid[2];
    logic [MSHR_ID_BITS-1:0] mRspId;
    logic [LINE_WIDTH-1:0] mRspData;

    logic [1:0] lastDutStall;
    logic [1:0] lastExpStall;

    typedef struct {
        logic [1:0]                   valid;
        logic [1:0]                   rw;
        logic [1:0][ADDR_WIDTH-1:0]   addr;
        logic [1:0][MSHR_ID_BITS-1:0] id;
        logic [1:0]                   expStall;
        logic                         expL2Valid;
        logic [ADDR_WIDTH-1:0]        expAddr;
        logic [MSHR_ID_BITS:0]        expId;
        logic                         expRw;
    } vec_t;

    vec_t vecs[5];

    l2_req_arbiter #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .LINE_WIDTH   (LINE_WIDTH),
        .MSHR_ID_BITS (MSHR_ID_BITS),
        .MAX_OUTST    (MAX_OUTST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .l1_addr_i  (l1_addr_i),
        .l1_data_i  (l1_data_i),
        .l1_rw_i    (l1_rw_i),
        .l1_valid_i (l1_valid_i),
        .l1_id_i    (l1_id_i),
        .l1_stall_o (l1_stall_o),
        .l1_data_o  (l1_data_o),
        .l1_valid_o (l1_valid_o),
        .l1_id_o    (l1_id_o),
        .l2_addr_o  (l2_addr_o),
        .l2_data_o  (l2_data_o),
        .l2_rw_o    (l2_rw_o),
        .l2_valid_o (l2_valid_o),
        .l2_id_o    (l2_id_o),
        .l2_stall_i (l2_stall_i),
        .l2_data_i  (l2_data_i),
        .l2_valid_i (l2_valid_i),
        .l2_id_i    (l2_id_i),
        .err_o      (err_o)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against any hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [LINE_WIDTH-1:0] randLine();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        l1_addr_i  = '0;
        l1_data_i  = '0;
        l1_rw_i    = 2'b00;
        l1_valid_i = 2'b00;
        l1_id_i    = '0;
        l2_stall_i = 1'b0;
        l2_data_i  = '0;
        l2_valid_i = 1'b0;
        l2_id_i    = '0;
    endtask

    task automatic modelReset();
        mStageValid  = 0;
        mAddr        = '0;
        mData        = '0;
        mRw          = 1'b0;
        mId          = '0;
        mPrefer      = 0;
        mCnt[0]      = 0;
        mCnt[1]      = 0;
        mErr         = 0;
        mRspValid[0] = 0;
        mRspValid[1] = 0;
        mRspId       = '0;
        mRspData     = '0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        clearInputs();
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Which port the rules say wins this cycle, -1 when nobody can compete
    function automatic int predictWinner();
        bit el0;
        bit el1;
        el0 = l1_valid_i[0] && !(l1_rw_i[0] == 1'b0 && mCnt[0] == MAX_OUTST);
        el1 = l1_valid_i[1] && !(l1_rw_i[1] == 1'b0 && mCnt[1] == MAX_OUTST);
        if (el0 && el1) return mPrefer;
        if (el0) return 0;
        if (el1) return 1;
        return -1;
    endfunction

    task automatic modelEdge(input int winner, input bit canLd);
        bit drain;
        int rp;
        drain        = mStageValid && !l2_stall_i;
        mRspValid[0] = 0;
        mRspValid[1] = 0;
        if (l2_valid_i) begin
            rp            = int'(l2_id_i[MSHR_ID_BITS]);
            mRspValid[rp] = 1;
            mRspId        = l2_id_i[MSHR_ID_BITS-1:0];
            mRspData      = l2_data_i;
            if (mCnt[rp] == 0) mErr = 1;
            else mCnt[rp] = mCnt[rp] - 1;
        end
        if (winner >= 0 && canLd) begin
            mStageValid = 1;
            mAddr       = l1_addr_i[winner];
            mData       = l1_data_i[winner];
            mRw         = l1_rw_i[winner];
            mId         = {1'(winner), l1_id_i[winner]};
            if (!l1_rw_i[winner]) mCnt[winner] = mCnt[winner] + 1;
            mPrefer = 1 - winner;
        end else if (drain) begin
            mStageValid = 0;
        end
    endtask

    // Runs one clock with the currently driven inputs, checking the stall
    // outputs before the edge and the registered outputs after it
    task automatic applyStimulus(input string tag);
        int   winner;
        bit   canLd;
        logic [1:0] expStall;
        #1;
        winner = predictWinner();
        canLd  = !mStageValid || !l2_stall_i;
        for (int p = 0; p < 2; p++) begin
            expStall[p] = l1_valid_i[p] && !(winner == p && canLd);
        end
        lastDutStall = l1_stall_o;
        lastExpStall = expStall;
        checkOutput({tag, "_stall"}, 256'(l1_stall_o), 256'(expStall));
        @(posedge clk);
        modelEdge(winner, canLd);
        #1;
        checkOutput({tag, "_l2valid"}, 256'(l2_valid_o), 256'(mStageValid));
        if (mStageValid) begin
            checkOutput({tag, "_l2addr"}, 256'(l2_addr_o), 256'(mAddr));
            checkOutput({tag, "_l2id"},   256'(l2_id_o),   256'(mId));
            checkOutput({tag, "_l2rw"},   256'(l2_rw_o),   256'(mRw));
            checkOutput({tag, "_l2data"}, l2_data_o, mData);
        end
        checkOutput({tag, "_rspvalid"}, 256'(l1_valid_o), 256'({mRspValid[1], mRspValid[0]}));
        for (int p = 0; p < 2; p++) begin
            if (mRspValid[p]) begin
                checkOutput({tag, "_rspid"},   256'(l1_id_o[p]), 256'(mRspId));
                checkOutput({tag, "_rspdata"}, l1_data_o[p], mRspData);
            end
        end
        checkOutput({tag, "_err"}, 256'(err_o), 256'(mErr));
        @(negedge clk);
    endtask

    initial begin
        logic [LINE_WIDTH-1:0] patA5;
        logic [1:0] expLoser;
        int rp;

        errors = 0;
        checks = 0;
        patA5  = {32{8'hA5}};
        doReset();

        // Reset values
        checkOutput("reset_l2valid", 256'(l2_valid_o), 256'(0));
        checkOutput("reset_err",     256'(err_o),      256'(0));
        checkOutput("reset_rspvalid", 256'(l1_valid_o), 256'(0));

        // Single-cycle vectors, each from a fresh reset
        vecs[0] = '{valid:2'b01, rw:2'b00, addr:{32'h0, 32'h0000_1240}, id:{4'd0, 4'd3},
                    expStall:2'b00, expL2Valid:1'b1, expAddr:32'h0000_1240, expId:5'b0_0011, expRw:1'b0};
        vecs[1] = '{valid:2'b10, rw:2'b10, addr:{32'h0000_2000, 32'h0}, id:{4'd7, 4'd0},
                    expStall:2'b00, expL2Valid:1'b1, expAddr:32'h0000_2000, expId:5'b1_0111, expRw:1'b1};
        vecs[2] = '{valid:2'b11, rw:2'b00, addr:{32'h0000_4000, 32'h0000_3000}, id:{4'd2, 4'd1},
                    expStall:2'b10, expL2Valid:1'b1, expAddr:32'h0000_3000, expId:5'b0_0001, expRw:1'b0};
        vecs[3] = '{valid:2'b00, rw:2'b00, addr:{32'h0000_1111, 32'h0000_2222}, id:{4'd5, 4'd6},
                    expStall:2'b00, expL2Valid:1'b0, expAddr:32'h0, expId:5'b0, expRw:1'b0};
        vecs[4] = '{valid:2'b11, rw:2'b11, addr:{32'h0000_6000, 32'h0000_5000}, id:{4'd9, 4'd15},
                    expStall:2'b10, expL2Valid:1'b1, expAddr:32'h0000_5000, expId:5'b0_1111, expRw:1'b1};
        for (int v = 0; v < 5; v++) begin
            doReset();
            l1_valid_i = vecs[v].valid;
            l1_rw_i    = vecs[v].rw;
            l1_addr_i  = vecs[v].addr;
            l1_id_i    = vecs[v].id;
            l1_data_i  = {randLine(), randLine()};
            applyStimulus("vec");
            checkOutput("vec_tbl_stall",   256'(lastDutStall), 256'(vecs[v].expStall));
            checkOutput("vec_tbl_l2valid", 256'(l2_valid_o),   256'(vecs[v].expL2Valid));
            if (vecs[v].expL2Valid) begin
                checkOutput("vec_tbl_addr", 256'(l2_addr_o), 256'(vecs[v].expAddr));
                checkOutput("vec_tbl_id",   256'(l2_id_o),   256'(vecs[v].expId));
                checkOutput("vec_tbl_rw",   256'(l2_rw_o),   256'(vecs[v].expRw));
            end
        end

        // Both ports always asking: grants alternate one per cycle
        doReset();
        l1_valid_i = 2'b11;
        l1_rw_i    = 2'b11;
        l1_addr_i  = {32'h0000_B000, 32'h0000_A000};
        for (int i = 0; i < 6; i++) begin
            applyStimulus("alt");
            expLoser = (i % 2 == 0) ? 2'b10 : 2'b01;
            checkOutput("alt_grant", 256'(l2_id_o[MSHR_ID_BITS]), 256'(i % 2));
            checkOutput("alt_loser", 256'(lastDutStall), 256'(expLoser));
        end

        // L2 backpressure holds the stage; release drains and reloads at once
        doReset();
        l1_valid_i   = 2'b01;
        l1_addr_i[0] = 32'h0000_7000;
        l1_id_i[0]   = 4'd1;
        l2_stall_i   = 1'b1;
        applyStimulus("bp_load");
        l1_valid_i   = 2'b11;
        l1_addr_i    = {32'h0000_8000, 32'h0000_7100};
        l1_id_i      = {4'd4, 4'd2};
        for (int k = 0; k < 3; k++) begin
            applyStimulus("bp_hold");
            checkOutput("bp_both_stall", 256'(lastDutStall), 256'(2'b11));
            checkOutput("bp_addr_held",  256'(l2_addr_o), 256'(32'h0000_7000));
            checkOutput("bp_id_held",    256'(l2_id_o),   256'(5'b0_0001));
        end
        l2_stall_i = 1'b0;
        applyStimulus("bp_release");
        checkOutput("bp_release_stall", 256'(lastDutStall), 256'(2'b01));
        checkOutput("bp_release_addr",  256'(l2_addr_o), 256'(32'h0000_8000));
        checkOutput("bp_release_id",    256'(l2_id_o),   256'(5'b1_0100));

        // Response routed to the I-cache
        doReset();
        l1_valid_i   = 2'b10;
        l1_addr_i[1] = 32'h0000_9000;
        l1_id_i[1]   = 4'd6;
        applyStimulus("rsp_req");
        l1_valid_i = 2'b00;
        l2_valid_i = 1'b1;
        l2_id_i    = 5'b1_0110;
        l2_data_i  = patA5;
        applyStimulus("rsp");
        checkOutput("rsp_valid", 256'(l1_valid_o), 256'(2'b10));
        checkOutput("rsp_id1",   256'(l1_id_o[1]), 256'(4'd6));
        checkOutput("rsp_data1", l1_data_o[1], patA5);
        checkOutput("rsp_noerr", 256'(err_o), 256'(0));
        l2_valid_i = 1'b0;
        applyStimulus("rsp_after");
        checkOutput("rsp_one_cycle", 256'(l1_valid_o), 256'(2'b00));

        // Read budget: the ninth read waits, a write still goes through
        doReset();
        l1_valid_i = 2'b10;
        l1_rw_i    = 2'b00;
        for (int i = 0; i < 8; i++) begin
            l1_id_i[1]   = 4'(i);
            l1_addr_i[1] = 32'h0000_A000 + 32'(i * 64);
            applyStimulus("lim_fill");
            checkOutput("lim_fill_stall", 256'(lastDutStall), 256'(2'b00));
        end
        l1_id_i[1] = 4'd8;
        applyStimulus("lim_ninth");
        checkOutput("lim_ninth_stall", 256'(lastDutStall), 256'(2'b10));
        l1_rw_i[1] = 1'b1;
        applyStimulus("lim_write");
        checkOutput("lim_write_stall", 256'(lastDutStall), 256'(2'b00));
        checkOutput("lim_write_rw",    256'(l2_rw_o), 256'(1));
        l1_rw_i[1] = 1'b0;
        l1_id_i[1] = 4'd9;
        l2_valid_i = 1'b1;
        l2_id_i    = 5'b1_0000;
        l2_data_i  = randLine();
        applyStimulus("lim_rsp");
        checkOutput("lim_rsp_stall", 256'(lastDutStall), 256'(2'b10));
        l2_valid_i = 1'b0;
        applyStimulus("lim_resume");
        checkOutput("lim_resume_stall", 256'(lastDutStall), 256'(2'b00));
        checkOutput("lim_resume_id",    256'(l2_id_o), 256'(5'b1_1001));

        // Spurious response, sticky error, asynchronous reset mid-transfer
        doReset();
        l2_valid_i = 1'b1;
        l2_id_i    = 5'b0_0000;
        l2_data_i  = randLine();
        applyStimulus("err_rsp");
        checkOutput("err_set",       256'(err_o), 256'(1));
        checkOutput("err_forwarded", 256'(l1_valid_o), 256'(2'b01));
        l2_valid_i = 1'b0;
        applyStimulus("err_idle");
        applyStimulus("err_idle");
        checkOutput("err_sticky", 256'(err_o), 256'(1));
        l1_valid_i   = 2'b01;
        l1_addr_i[0] = 32'h0000_C000;
        l2_stall_i   = 1'b1;
        applyStimulus("mid_load");
        l1_valid_i = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_l2valid", 256'(l2_valid_o), 256'(0));
        checkOutput("arst_l2addr",  256'(l2_addr_o),  256'(0));
        checkOutput("arst_l2id",    256'(l2_id_o),    256'(0));
        checkOutput("arst_err",     256'(err_o),      256'(0));
        checkOutput("arst_stall",   256'(l1_stall_o), 256'(0));
        checkOutput("arst_rspvalid", 256'(l1_valid_o), 256'(0));
        checkOutput("arst_rspdata", l1_data_o[0], 256'(0));
        clearInputs();
        modelReset();
        @(negedge clk);
        reset      = 1'b1;
        l2_valid_i = 1'b1;
        l2_id_i    = 5'b1_0011;
        l2_data_i  = randLine();
        applyStimulus("late_rsp");
        checkOutput("late_rsp_err", 256'(err_o), 256'(1));

        // Randomized traffic against the model
        doReset();
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(l1_valid_i[p] && lastExpStall[p])) begin
                    l1_valid_i[p] = ($urandom_range(0, 3) != 0);
                    l1_rw_i[p]    = ($urandom_range(0, 3) == 0);
                    l1_addr_i[p]  = $urandom();
                    l1_data_i[p]  = randLine();
                    l1_id_i[p]    = 4'($urandom_range(0, 15));
                end
            end
            l2_stall_i = ($urandom_range(0, 3) == 0);
            l2_valid_i = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                rp = int'($urandom_range(0, 1));
                if (mCnt[rp] == 0) rp = 1 - rp;
                if (mCnt[rp] > 0) begin
                    l2_valid_i = 1'b1;
                    l2_id_i    = {1'(rp), 4'($urandom_range(0, 15))};
                    l2_data_i  = randLine();
                end
            end
            applyStimulus("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
